fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of an in-order pipeline. It issues word-aligned
// requests to an instruction memory that may insert wait states, and it
// presents each fetched word in the IF/ID pipeline register together with its
// PC and PC+4.
//
// The hazard unit can do three things to this stage:
//   stall        : hold the IF/ID register.
//   flush        : load IF/ID with a bubble.
//   branch_taken : redirect the PC to branch_target.
//
// If a word returns while IF/ID is stalled, it is parked in a one-entry
// buffer, and memory requests pause until the stall clears.
//
// If a redirect arrives while a request is still waiting on memory, the
// request is allowed to finish at its original address and its data is
// thrown away. This keeps the memory handshake legal: the address is never
// changed while a request is pending.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   stall          in   hold IF/ID
//   flush          in   force a bubble into IF/ID
//   branch_taken   in   redirect request
//   branch_target  in   redirect address (bits [1:0] ignored)
//   imem_req       out  instruction-memory request valid
//   imem_addr      out  request address
//   imem_ready     in   memory returns imem_rdata this cycle
//   imem_rdata     in   instruction word, valid with imem_ready
//   instruction    out  IF/ID instruction
//   pc_current     out  IF/ID PC of instruction
//   pc_plus_4      out  IF/ID pc_current + 4
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                         data_width    = 32,
    parameter int                         address_width = 12,
    parameter logic [address_width-1:0]   RESET_PC      = 12'h000,
    parameter logic [data_width-1:0]      NOP_INSTR     = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     branch_taken,
    input  logic [address_width-1:0] branch_target,
    output logic                     imem_req,
    output logic [address_width-1:0] imem_addr,
    input  logic                     imem_ready,
    input  logic [data_width-1:0]    imem_rdata,
    output logic [data_width-1:0]    instruction,
    output logic [address_width-1:0] pc_current,
    output logic [address_width-1:0] pc_plus_4
);

    // FETCH   : requesting at pc.
    // DISCARD : finishing an abandoned request at kill_addr; its data is dropped.
    // HOLD    : a returned word is parked in hold_buf while IF/ID is stalled.
    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_DISCARD = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [address_width-1:0] PC_STEP    = address_width'(4);
    localparam logic [address_width-1:0] ALIGN_MASK = ~address_width'(3);

    // Instructions are word-aligned, so the two low address bits are always zero.
    function automatic logic [address_width-1:0] word_align(
        input logic [address_width-1:0] addr
    );
        return addr & ALIGN_MASK;
    endfunction

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [address_width-1:0] r_pc;
    logic [address_width-1:0] w_pc_nxt;
    logic [address_width-1:0] w_pc_inc;
    logic [address_width-1:0] r_kill_addr;
    logic [address_width-1:0] w_kill_nxt;
    logic [data_width-1:0]    r_hold_buf;
    logic [data_width-1:0]    w_hold_nxt;

    // IF/ID register update controls
    logic                     w_ifid_load;
    logic                     w_ifid_bubble;
    logic [data_width-1:0]    w_ifid_word;

    logic [data_width-1:0]    r_instr_p1;
    logic [address_width-1:0] r_pc_p1;
    logic [address_width-1:0] r_pc4_p1;

    // The PC wraps naturally at the top of the address space.
    assign w_pc_inc = r_pc + PC_STEP;

    // HOLD pauses new requests. In DISCARD, the abandoned address stays on the
    // bus until memory finishes that request.
    assign imem_req  = (r_state != ST_HOLD);
    assign imem_addr = (r_state == ST_DISCARD) ? r_kill_addr : r_pc;

    // -----------------------------------------------------------------------
    // Next-state and IF/ID control.
    //
    // The IF/ID update follows one rule in every state:
    //   - flush                : always a bubble;
    //   - a word is delivered  : load it;
    //   - stall (nothing else) : hold;
    //   - otherwise            : bubble.
    //
    // branch_taken always owns the next PC, whether or not IF/ID is stalled.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_kill_nxt    = r_kill_addr;
        w_hold_nxt    = r_hold_buf;
        w_ifid_load   = 1'b0;
        w_ifid_bubble = 1'b0;
        w_ifid_word   = imem_rdata;

        case (r_state)
            ST_FETCH: begin
                if (branch_taken) begin
                    w_pc_nxt      = word_align(branch_target);
                    w_ifid_bubble = flush || !stall;
                    // A word that has already returned is simply dropped. A
                    // request still in flight must complete first, so remember
                    // its address and drain it in DISCARD.
                    if (!imem_ready) begin
                        w_kill_nxt  = r_pc;
                        w_state_nxt = ST_DISCARD;
                    end
                end else if (flush) begin
                    // The returned word (if any) is dropped and the PC stays,
                    // so the same address is fetched again.
                    w_ifid_bubble = 1'b1;
                end else if (imem_ready && !stall) begin
                    w_ifid_load = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                end else if (imem_ready) begin
                    w_hold_nxt  = imem_rdata;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_ifid_bubble = !stall;
                end
            end

            ST_DISCARD: begin
                // A later redirect replaces an earlier one.
                if (branch_taken) begin
                    w_pc_nxt = word_align(branch_target);
                end
                if (imem_ready) begin
                    w_state_nxt = ST_FETCH;
                end
                w_ifid_bubble = flush || !stall;
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    // The parked word is on the wrong path; just leave it unused.
                    w_pc_nxt      = word_align(branch_target);
                    w_state_nxt   = ST_FETCH;
                    w_ifid_bubble = flush || !stall;
                end else if (flush) begin
                    // The PC was not advanced for the parked word, so it will
                    // be fetched again from the same address.
                    w_state_nxt   = ST_FETCH;
                    w_ifid_bubble = 1'b1;
                end else if (!stall) begin
                    w_ifid_load = 1'b1;
                    w_ifid_word = r_hold_buf;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Fetch control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_pc        <= word_align(RESET_PC);
            r_kill_addr <= '0;
            r_hold_buf  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_kill_addr <= w_kill_nxt;
            r_hold_buf  <= w_hold_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // IF/ID pipeline register (stage 1)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_p1 <= NOP_INSTR;
            r_pc_p1    <= '0;
            r_pc4_p1   <= '0;
        end else if (w_ifid_bubble) begin
            r_instr_p1 <= NOP_INSTR;
            r_pc_p1    <= '0;
            r_pc4_p1   <= '0;
        end else if (w_ifid_load) begin
            r_instr_p1 <= w_ifid_word;
            r_pc_p1    <= r_pc;
            r_pc4_p1   <= w_pc_inc;
        end
    end

    assign instruction = r_instr_p1;
    assign pc_current  = r_pc_p1;
    assign pc_plus_4   = r_pc4_p1;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Drives fetch_stage with directed scenarios and then with a long random
// stream.
//
// The instruction memory is a fixed hash of the address. The reference model
// tracks fetch progress at transaction level:
//   - the PC;
//   - whether an abandoned request is still draining;
//   - a queue holding a parked word;
//   - the expected IF/ID contents.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [11:0] branch_target = 12'h000;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic [11:0] pc_current;
    logic [11:0] pc_plus_4;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_pc;
    bit          m_drop;
    int          m_kill;
    logic [31:0] m_held[$];
    logic [31:0] m_instr;
    int          m_pcc;
    int          m_pc4;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instruction   (instruction),
        .pc_current    (pc_current),
        .pc_plus_4     (pc_plus_4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input int a);
        logic [31:0] x;
        x = 32'(a);
        return (x * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int exp_addr();
        return m_drop ? m_kill : m_pc;
    endfunction

    task automatic model_reset();
        m_pc    = 0;
        m_drop  = 1'b0;
        m_kill  = 0;
        m_held.delete();
        m_instr = NOP;
        m_pcc   = 0;
        m_pc4   = 0;
    endtask

    task automatic check_outputs();
        chk("imem_req",    32'(imem_req),    32'(m_held.size() == 0));
        chk("imem_addr",   32'(imem_addr),   32'(exp_addr()));
        chk("instruction", instruction,      m_instr);
        chk("pc_current",  32'(pc_current),  32'(m_pcc));
        chk("pc_plus_4",   32'(pc_plus_4),   32'(m_pc4));
        // Any non-bubble in IF/ID must be the memory word at its own PC.
        if (instruction !== NOP)
            chk("word_at_pc", instruction, mem_word(32'(pc_current)));
    endtask

    // Called at a falling edge: drive one cycle's inputs, advance the model
    // at the rising edge, then check the outputs at the next falling edge.
    task automatic cycle(input bit st, input bit fl, input bit br, input int tgt, input bit rdy);
        bit          was_held;
        bit          was_drop;
        bit          xfer;
        bit          deliver;
        bit          park;
        logic [31:0] w;
        int          base;

        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = 12'(tgt);
        imem_ready    = rdy;
        imem_rdata    = rdy ? mem_word(exp_addr()) : $urandom();

        @(posedge clk);

        was_held = (m_held.size() != 0);
        was_drop = m_drop;
        xfer     = !was_held && rdy;
        base     = m_pc;
        deliver  = 1'b0;
        park     = 1'b0;
        w        = '0;

        if (!br && !fl) begin
            if (was_held && !st) begin
                deliver = 1'b1;
                w       = m_held[0];
            end else if (!was_drop && xfer) begin
                if (st) begin
                    park = 1'b1;
                end else begin
                    deliver = 1'b1;
                    w       = imem_rdata;
                end
            end
        end

        if (!was_held && !was_drop && br && !rdy) begin
            m_drop = 1'b1;
            m_kill = m_pc;
        end else if (was_drop && rdy) begin
            m_drop = 1'b0;
        end

        if (br || fl || deliver) m_held.delete();
        if (park) m_held.push_back(imem_rdata);

        if (br)           m_pc = tgt & 32'hFFC;
        else if (deliver) m_pc = (m_pc + 4) % 4096;

        if (fl) begin
            m_instr = NOP; m_pcc = 0; m_pc4 = 0;
        end else if (deliver) begin
            m_instr = w; m_pcc = base; m_pc4 = (base + 4) % 4096;
        end else if (!st) begin
            m_instr = NOP; m_pcc = 0; m_pc4 = 0;
        end

        @(negedge clk);
        check_outputs();
    endtask

    // Called at a falling edge: assert reset, check the asynchronous clear,
    // then release reset on the next falling edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_instruction", instruction,      NOP);
        chk("rst_pc_current",  32'(pc_current),  32'h0);
        chk("rst_pc_plus_4",   32'(pc_plus_4),   32'h0);
        chk("rst_imem_addr",   32'(imem_addr),   32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_outputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Zero-wait stream from 0x000.
        cycle(0, 0, 0, 0, 1);
        chk("s0_instr", instruction, mem_word(0));
        chk("s0_pc",    32'(pc_current), 32'h000);
        chk("s0_pc4",   32'(pc_plus_4),  32'h004);
        cycle(0, 0, 0, 0, 1);
        chk("s1_instr", instruction, mem_word(4));
        chk("s1_pc",    32'(pc_current), 32'h004);
        cycle(0, 0, 0, 0, 1);
        chk("s2_instr", instruction, mem_word(8));
        chk("s2_pc4",   32'(pc_plus_4),  32'h00C);

        // Wait states at 0x010.
        cycle(0, 0, 1, 'h010, 1);
        chk("ws_addr0", 32'(imem_addr), 32'h010);
        cycle(0, 0, 0, 0, 0);
        chk("ws_addr1", 32'(imem_addr), 32'h010);
        chk("ws_bub1",  instruction, NOP);
        cycle(0, 0, 0, 0, 0);
        chk("ws_addr2", 32'(imem_addr), 32'h010);
        chk("ws_bub2",  instruction, NOP);
        cycle(0, 0, 0, 0, 1);
        chk("ws_pc",    32'(pc_current), 32'h010);
        chk("ws_instr", instruction, mem_word('h010));

        // Stall on return at 0x020 (the target's low bits are ignored).
        cycle(0, 0, 1, 'h023, 1);
        cycle(1, 0, 0, 0, 1);
        chk("st_req0",  32'(imem_req), 32'h0);
        chk("st_hold0", instruction, NOP);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        chk("st_req2",  32'(imem_req), 32'h0);
        chk("st_hold2", 32'(pc_current), 32'h000);
        cycle(0, 0, 0, 0, 0);
        chk("st_instr", instruction, mem_word('h020));
        chk("st_pc",    32'(pc_current), 32'h020);
        chk("st_pc4",   32'(pc_plus_4),  32'h024);
        chk("st_next",  32'(imem_addr),  32'h024);

        // Redirect while waiting at 0x030.
        cycle(0, 0, 1, 'h030, 1);
        cycle(0, 1, 1, 'h100, 0);
        chk("rd_addr0", 32'(imem_addr), 32'h030);
        chk("rd_bub0",  instruction, NOP);
        cycle(0, 0, 0, 0, 0);
        chk("rd_addr1", 32'(imem_addr), 32'h030);
        cycle(0, 0, 0, 0, 1);
        chk("rd_addr2", 32'(imem_addr), 32'h100);
        chk("rd_bub2",  instruction, NOP);

        // Wrap at 0xFFC, then reset while a request is waiting.
        cycle(0, 0, 1, 'hFFC, 1);
        cycle(0, 0, 0, 0, 1);
        chk("wr_pc",   32'(pc_current), 32'hFFC);
        chk("wr_pc4",  32'(pc_plus_4),  32'h000);
        chk("wr_addr", 32'(imem_addr),  32'h000);
        cycle(0, 0, 0, 0, 0);
        do_reset();
        chk("rs_addr", 32'(imem_addr), 32'h000);

        // Random stream with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(99) < 25, $urandom_range(99) < 8,
                      $urandom_range(99) < 10, int'($urandom_range(4095)),
                      $urandom_range(99) < 60);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
